// File: rtl/periplex_cmd_sched.sv
// periplex_cmd_sched: pops packets from the host RX byte FIFO, issues lane
// write strobes, answers lane reads through the TX FIFO.
// Ports: clock, reset (async, high); RX FIFO rx_empty/rx_data/rx_read;
//  TX FIFO tx_full/tx_write/tx_data; lane strobes tgt_cfg_we/tgt_data_we
//  with payload tgt_wdata; packed lane inputs tgt_rdata; busy; err/err_clr.
// Macro PERIPLEX_CMD_TIMEOUT_EN: abandon a packet whose payload byte does
//  not arrive within TIMEOUT cycles.
module periplex_cmd_sched #(
  parameter int DATAWIDTH   = 8,
  parameter int NUM_TARGETS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             rx_empty,
  input  logic [DATAWIDTH-1:0]             rx_data,
  output logic                             rx_read,
  input  logic                             tx_full,
  output logic                             tx_write,
  output logic [DATAWIDTH-1:0]             tx_data,
  output logic [NUM_TARGETS-1:0]           tgt_cfg_we,
  output logic [NUM_TARGETS-1:0]           tgt_data_we,
  output logic [DATAWIDTH-1:0]             tgt_wdata,
  input  logic [NUM_TARGETS*DATAWIDTH-1:0] tgt_rdata,
  output logic                             busy,
  output logic                             err,
  input  logic                             err_clr
);

  typedef enum logic [2:0] {
    IDLE, H_WAIT, H_CAP, D_REQ, D_WAIT, D_CAP, ISSUE, RESP
  } state_t;

  localparam logic [1:0] OP_WR_DATA = 2'b00;
  localparam logic [1:0] OP_WR_CFG  = 2'b01;
  localparam logic [1:0] OP_RD      = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;
  localparam logic [3:0] NT         = 4'(NUM_TARGETS);

  state_t                 state, state_nx;
  logic [2:0]             tgt_q;
  logic [1:0]             op_q;
  logic                   rd_nx, tx_nx, err_set;
  logic [2:0]             hdr_tgt;
  logic [1:0]             hdr_op;
  logic                   hdr_ok;
  logic                   to_hit;
  logic [NUM_TARGETS-1:0] sel;
  logic [DATAWIDTH-1:0]   lane_word;

  assign hdr_tgt = rx_data[7:5];
  assign hdr_op  = rx_data[4:3];
  assign hdr_ok  = {1'b0, hdr_tgt} < NT;
  assign busy    = state != IDLE;

`ifdef PERIPLEX_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Counts consecutive empty cycles spent waiting for the payload byte.
  assign to_hit = rx_empty && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      to_cnt <= '0;
    else if (state == D_REQ && rx_empty)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
  assign to_hit = 1'b0;
`endif

  // Ids without a lane select nothing and read back all-ones.
  always_comb begin
    sel       = '0;
    lane_word = '1;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (tgt_q == 3'(k)) begin
        sel[k]    = 1'b1;
        lane_word = tgt_rdata[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    state_nx = state;
    rd_nx    = 1'b0;
    tx_nx    = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_empty) begin
          rd_nx    = 1'b1;
          state_nx = H_WAIT;
        end
      end
      H_WAIT: state_nx = H_CAP;
      H_CAP: begin
        err_set = !hdr_ok && (hdr_op != OP_NOP);
        unique case (hdr_op)
          OP_WR_DATA,
          OP_WR_CFG: state_nx = D_REQ;
          OP_RD:     state_nx = RESP;
          default:   state_nx = IDLE;
        endcase
      end
      D_REQ: begin
        if (!rx_empty) begin
          rd_nx    = 1'b1;
          state_nx = D_WAIT;
        end else if (to_hit) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end
      end
      D_WAIT: state_nx = D_CAP;
      D_CAP:  state_nx = ISSUE;
      ISSUE:  state_nx = IDLE;
      RESP: begin
        if (!tx_full) begin
          tx_nx    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tgt_q       <= '0;
      op_q        <= '0;
      rx_read     <= 1'b0;
      tx_write    <= 1'b0;
      tx_data     <= '0;
      tgt_cfg_we  <= '0;
      tgt_data_we <= '0;
      tgt_wdata   <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      rx_read     <= rd_nx;
      tx_write    <= tx_nx;
      tgt_cfg_we  <= '0;
      tgt_data_we <= '0;
      if (state == H_CAP) begin
        tgt_q <= hdr_tgt;
        op_q  <= hdr_op;
      end
      if (tx_nx)
        tx_data <= lane_word;
      // Strobe is registered so it is high exactly while in ISSUE.
      if (state == D_CAP) begin
        tgt_wdata <= rx_data;
        if (op_q == OP_WR_CFG)
          tgt_cfg_we <= sel;
        else
          tgt_data_we <= sel;
      end
      // A new error beats a simultaneous clear.
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_periplex_cmd_sched.sv
// tb_periplex_cmd_sched: directed and randomized bench for periplex_cmd_sched.
// Packets are expanded into expected strobe/push events by a packet model.
`timescale 1ns/1ps
module tb_periplex_cmd_sched;
  localparam int DW = 8;
  localparam int NT = 4;

  typedef struct {
    bit         rd;
    bit         cfg;
    int         lane;
    logic [7:0] data;
  } ev_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rx_empty;
  logic [DW-1:0]    rx_data = '0;
  logic             rx_read;
  logic             tx_full = 1'b0;
  logic             tx_write;
  logic [DW-1:0]    tx_data;
  logic [NT-1:0]    tgt_cfg_we;
  logic [NT-1:0]    tgt_data_we;
  logic [DW-1:0]    tgt_wdata;
  logic [NT*DW-1:0] tgt_rdata = '0;
  logic             busy;
  logic             err;
  logic             err_clr = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] rxq[$];
  int         rx_pushes = 0;
  int         rx_pops   = 0;
  logic [7:0] stream[$];
  ev_t        evq[$];
  logic [7:0] word[NT];
  bit         err_exp = 1'b0;
  bit         prev_rd = 1'b0;
  logic       full_q  = 1'b0;
  ev_t        ce;

  int         o_str, o_sidx, o_tx, o_tidx, o_busy;
  logic [3:0] o_cv, o_dv;
  logic [7:0] o_wd, o_td;

  assign rx_empty = (rx_pushes == rx_pops);

  periplex_cmd_sched #(
    .DATAWIDTH(DW), .NUM_TARGETS(NT), .TIMEOUT(255)
  ) dut (
    .clock(clock), .reset(reset),
    .rx_empty(rx_empty), .rx_data(rx_data), .rx_read(rx_read),
    .tx_full(tx_full), .tx_write(tx_write), .tx_data(tx_data),
    .tgt_cfg_we(tgt_cfg_we), .tgt_data_we(tgt_data_we),
    .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, want);
    end
  endtask

  // RX FIFO with registered read data: pop on the edge that sees rx_read.
  always @(posedge clock) begin
    full_q <= tx_full;
    if (rx_read && rx_pops < rx_pushes) begin
      rx_data <= rxq[rx_pops];
      rx_pops <= rx_pops + 1;
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
    rx_pushes++;
  endtask

  task automatic set_words();
    for (int k = 0; k < NT; k++) tgt_rdata[k*DW +: DW] = word[k];
  endtask

  // Packet model: what each packet must produce on the outputs.
  task automatic add_pkt(input logic [7:0] h, input logic [7:0] p);
    int  t;
    int  op;
    ev_t e;
    t = int'(h[7:5]);
    op = int'(h[4:3]);
    stream.push_back(h);
    if (op == 3) return;
    e.lane = t;
    e.rd   = (op == 2);
    e.cfg  = (op == 1);
    e.data = p;
    if (op != 2) stream.push_back(p);
    if (t >= NT) err_exp = 1'b1;
    if (op == 2) begin
      e.data = (t < NT) ? word[t] : 8'hFF;
      evq.push_back(e);
    end else if (t < NT) begin
      evq.push_back(e);
    end
  endtask

  task automatic feed_now();
    while (stream.size() != 0) push_rx(stream.pop_front());
  endtask

  task automatic observe(input int n);
    o_str = 0; o_sidx = 0; o_tx = 0; o_tidx = 0; o_busy = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      if (busy) o_busy++;
      if (tgt_cfg_we != '0 || tgt_data_we != '0) begin
        o_str++; o_sidx = i;
        o_cv = tgt_cfg_we; o_dv = tgt_data_we; o_wd = tgt_wdata;
      end
      if (tx_write) begin
        o_tx++; o_tidx = i; o_td = tx_data;
      end
    end
  endtask

  // Every cycle: each strobe / push must be the next expected event.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_read) begin
        chk("rx_read_while_empty", rx_empty, 1'b0);
        chk("rx_read_in_flight", prev_rd, 1'b0);
      end
      prev_rd = rx_read;
      if (tgt_cfg_we != '0 || tgt_data_we != '0) begin
        if (evq.size() == 0) begin
          chk("strobe_unexpected", {tgt_cfg_we, tgt_data_we}, 0);
        end else begin
          ce = evq.pop_front();
          chk("strobe_kind", ce.rd, 1'b0);
          chk("strobe_cfg", tgt_cfg_we, ce.cfg ? 4'(1 << ce.lane) : 4'h0);
          chk("strobe_data", tgt_data_we, ce.cfg ? 4'h0 : 4'(1 << ce.lane));
          chk("strobe_wdata", tgt_wdata, ce.data);
        end
      end
      if (tx_write) begin
        chk("tx_write_while_full", full_q, 1'b0);
        if (evq.size() == 0) begin
          chk("tx_unexpected", tx_write, 1'b0);
        end else begin
          ce = evq.pop_front();
          chk("tx_kind", ce.rd, 1'b1);
          chk("tx_data", tx_data, ce.data);
        end
      end
    end
  end

  initial begin
    word[0] = 8'h81; word[1] = 8'h42; word[2] = 8'h3C; word[3] = 8'hE7;
    set_words();
    #12;
    chk("rst_rx_read", rx_read, 0);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_strobes", {tgt_cfg_we, tgt_data_we}, 0);
    chk("rst_wdata", tgt_wdata, 0);
    chk("rst_busy_err", {busy, err}, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // tgt1 WR_DATA: strobe in the 7th cycle of the packet
    add_pkt(8'h20, 8'hA5); feed_now(); observe(10);
    chk("t2_strobes", o_str, 1);
    chk("t2_data_we", o_dv, 4'b0010);
    chk("t2_cfg_we", o_cv, 4'b0000);
    chk("t2_wdata", o_wd, 8'hA5);
    chk("t2_strobe_cycle", o_sidx, 6);
    chk("t2_busy_cycles", o_busy, 6);
    chk("t2_wdata_held", tgt_wdata, 8'hA5);

    // 0x28 decodes as tgt1 WR_CFG
    add_pkt(8'h28, 8'h5A); feed_now(); observe(10);
    chk("t2b_cfg_we", o_cv, 4'b0010);
    chk("t2b_data_we", o_dv, 4'b0000);

    // tgt3 WR_CFG
    add_pkt(8'h68, 8'h0F); feed_now(); observe(10);
    chk("t3_cfg_we", o_cv, 4'b1000);
    chk("t3_data_we", o_dv, 4'b0000);
    chk("t3_wdata", o_wd, 8'h0F);

    // tgt2 RD held off by a full TX FIFO
    tx_full = 1'b1;
    add_pkt(8'h50, 8'h00); feed_now(); observe(10);
    chk("t4_no_push_full", o_tx, 0);
    chk("t4_busy_stalled", busy, 1);
    tx_full = 1'b0;
    observe(5);
    chk("t4_push_count", o_tx, 1);
    chk("t4_push_data", o_td, 8'h3C);

    // RD timing with free TX: push in the 5th cycle of the packet
    add_pkt(8'h57, 8'h00); feed_now(); observe(8);
    chk("t4b_push_cycle", o_tidx, 4);
    chk("t4b_push_data", o_td, 8'h3C);

    // Invalid target write: both bytes consumed, no strobe, err
    add_pkt(8'hA0, 8'h11); feed_now(); observe(10);
    chk("t5_no_strobe", o_str, 0);
    chk("t5_rx_consumed", rx_empty, 1);
    chk("t5_err_set", err, 1);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    err_exp = 1'b0;
    chk("t5_err_cleared", err, 0);

    // Invalid read with err_clr on the same edge the error is raised
    add_pkt(8'hB0, 8'h00); feed_now();
    repeat (2) @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("t5_err_wins", err, 1);
    observe(4);
    chk("t5_rd_push", o_tx, 1);
    chk("t5_rd_ones", o_td, 8'hFF);

    // Reset during ISSUE
    add_pkt(8'h20, 8'h33); feed_now();
    repeat (6) @(negedge clock);
    chk("t1_in_issue", tgt_data_we, 4'b0010);
    #2 reset = 1'b1;
    #1;
    chk("t1_strobes_low", {tgt_cfg_we, tgt_data_we}, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_err_low", err, 0);
    rx_pushes = rx_pops;
    stream.delete(); evq.delete();
    err_exp = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    observe(12);
    chk("t1_quiet_strobes", o_str, 0);
    chk("t1_quiet_tx", o_tx, 0);

    // Randomized packet stream with random RX gaps and TX back-pressure
    for (int k = 0; k < NT; k++) word[k] = 8'($urandom);
    set_words();
    for (int n = 0; n < 80; n++) add_pkt(8'($urandom), 8'($urandom));
    while (stream.size() != 0) begin
      @(negedge clock);
      tx_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) push_rx(stream.pop_front());
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      tx_full = ($urandom_range(0, 3) == 0);
      if (rx_empty && !busy && evq.size() == 0) break;
    end
    tx_full = 1'b0;
    repeat (4) @(negedge clock);
    chk("rand_events_left", evq.size(), 0);
    chk("rand_rx_left", rx_pushes - rx_pops, 0);
    chk("rand_err", err, err_exp);

`ifdef PERIPLEX_CMD_TIMEOUT_EN
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    push_rx(8'h08);
    observe(300);
    chk("t6_no_strobe", o_str, 0);
    chk("t6_err", err, 1);
    chk("t6_idle", busy, 0);
    ce.rd = 1'b1; ce.cfg = 1'b0; ce.lane = 3; ce.data = word[3];
    evq.push_back(ce);
    push_rx(8'h77);
    observe(8);
    chk("t6_hdr_push", o_tx, 1);
    chk("t6_hdr_data", o_td, word[3]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
